// File: rtl/onehot_seq_pkg.sv
// Shared constants for the one-hot sequence monitor: FSM state codes, the expected
// 16-step phase table and the active-low 7-segment digit table.
package onehot_seq_pkg;

  typedef logic [0:0] state_t;

  localparam state_t StSync  = 1'b0;
  localparam state_t StTrack = 1'b1;

  // Index 0 is the rightmost element: phase 0..15 = 01,02,01,04,01,08,01,10,
  // 01,20,01,40,01,80,00,00.
  localparam logic [15:0][7:0] EXP_SEQ = {
    8'h00, 8'h00, 8'h80, 8'h01, 8'h40, 8'h01, 8'h20, 8'h01,
    8'h10, 8'h01, 8'h08, 8'h01, 8'h04, 8'h01, 8'h02, 8'h01
  };

  // Active-low {g,f,e,d,c,b,a} for digits 7..0 (index 0 is the rightmost element).
  localparam logic [7:0][6:0] SEG7 = {
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7_digit(input logic [2:0] digit);
    return SEG7[digit];
  endfunction

endpackage

// File: rtl/onehot_enc8.sv
// Combinational 8->3 encoder: index of the highest set bit, plus a flag for
// patterns with more than one bit set. 00 and 01 both encode to 0.
module onehot_enc8 (
  input  logic [7:0] pat,
  output logic [2:0] idx,
  output logic       multi
);

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pat[i]) begin
        idx = 3'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi = |(pat & (pat - 8'd1));

endmodule

// File: rtl/onehot_seq_monitor.sv
// Encodes one-hot phase samples, tracks them against the fixed 16-step sequence and
// counts errors and laps. Define ONEHOT_SEG_EN to build the registered 7-seg decoder.
module onehot_seq_monitor
  import onehot_seq_pkg::*;
#(
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned LAP_W    = 8,
  parameter int unsigned LOSS_LIM = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       pat_in,
  input  logic             pat_valid,
  output logic [2:0]       idx,
  output logic             idx_valid,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count,
  output logic [LAP_W-1:0] lap_count,
  output logic [6:0]       seg
);

  localparam logic [3:0] LossLim = 4'(LOSS_LIM);

  logic [2:0] enc_idx;
  logic       enc_multi;

  onehot_enc8 u_enc (
    .pat   (pat_in),
    .idx   (enc_idx),
    .multi (enc_multi)
  );

  state_t           state_q, state_d;
  logic [3:0]       phase_q, phase_d;
  logic [3:0]       miss_q, miss_d;
  logic [3:0]       miss_inc;
  logic             lap_full_q, lap_full_d;
  logic [2:0]       idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             onehot_err_q, onehot_err_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             match;

  assign match    = (pat_in == EXP_SEQ[phase_q]);
  assign miss_inc = miss_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    miss_d       = miss_q;
    lap_full_d   = lap_full_q;
    idx_d        = idx_q;
    idx_valid_d  = 1'b0;
    onehot_err_d = onehot_err_q;
    seq_err_d    = seq_err_q;
    err_d        = err_q;
    lap_d        = lap_q;

    if (pat_valid) begin
      idx_valid_d  = 1'b1;
      idx_d        = enc_idx;
      onehot_err_d = enc_multi;
      seq_err_d    = 1'b0;
      case (state_q)
        StSync: begin
          if (pat_in == 8'h80) begin
            state_d    = StTrack;
            phase_d    = 4'd14;
            miss_d     = 4'd0;
            lap_full_d = 1'b0;
          end
        end
        StTrack: begin
          phase_d = phase_q + 4'd1;
          // A lap only counts once it has been followed from phase 0 while locked.
          if (phase_q == 4'd15) begin
            lap_full_d = 1'b1;
          end
          if (match) begin
            miss_d = 4'd0;
            if (phase_q == 4'd15 && lap_full_q) begin
              lap_d = lap_q + LAP_W'(1);
            end
          end else begin
            seq_err_d = 1'b1;
            if (err_q != {ERR_W{1'b1}}) begin
              err_d = err_q + ERR_W'(1);
            end
            if (miss_inc == LossLim) begin
              state_d    = StSync;
              miss_d     = 4'd0;
              lap_full_d = 1'b0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StSync;
      phase_q      <= 4'd0;
      miss_q       <= 4'd0;
      lap_full_q   <= 1'b0;
      idx_q        <= 3'd0;
      idx_valid_q  <= 1'b0;
      onehot_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      err_q        <= '0;
      lap_q        <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      miss_q       <= miss_d;
      lap_full_q   <= lap_full_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      onehot_err_q <= onehot_err_d;
      seq_err_q    <= seq_err_d;
      err_q        <= err_d;
      lap_q        <= lap_d;
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign onehot_err = onehot_err_q;
  assign seq_err    = seq_err_q;
  assign locked     = (state_q == StTrack);
  assign err_count  = err_q;
  assign lap_count  = lap_q;

`ifdef ONEHOT_SEG_EN
  logic [6:0] seg_q, seg_d;

  assign seg_d = (state_d == StTrack) ? seg7_digit(idx_d) : SEG_BLANK;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_BLANK;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;
`else
  assign seg = SEG_BLANK;
`endif

endmodule

// File: tb/tb_onehot_seq_monitor.sv
// Directed bench for onehot_seq_monitor (default build, 7-seg decoder disabled).
module tb_onehot_seq_monitor;

  logic       clk;
  logic       reset;
  logic [7:0] pat_in;
  logic       pat_valid;
  logic [2:0] idx;
  logic       idx_valid;
  logic       onehot_err;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_count;
  logic [7:0] lap_count;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;
  int exp_err;

  logic [7:0] seq_tab [16] = '{8'h01, 8'h02, 8'h01, 8'h04, 8'h01, 8'h08, 8'h01, 8'h10,
                               8'h01, 8'h20, 8'h01, 8'h40, 8'h01, 8'h80, 8'h00, 8'h00};
  int         idx_tab [16] = '{0, 1, 0, 2, 0, 3, 0, 4, 0, 5, 0, 6, 0, 7, 0, 0};

  onehot_seq_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .pat_in     (pat_in),
    .pat_valid  (pat_valid),
    .idx        (idx),
    .idx_valid  (idx_valid),
    .onehot_err (onehot_err),
    .seq_err    (seq_err),
    .locked     (locked),
    .err_count  (err_count),
    .lap_count  (lap_count),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] p, input logic v);
    @(negedge clk);
    pat_in    = p;
    pat_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [7:0] p, input int e_idx,
                      input logic e_lock, input logic e_seq, input logic e_oh);
    drive(p, 1'b1);
    check({tag, ".idx_valid"}, idx_valid, 1);
    check({tag, ".idx"}, idx, e_idx);
    check({tag, ".locked"}, locked, e_lock);
    check({tag, ".seq_err"}, seq_err, e_seq);
    check({tag, ".onehot_err"}, onehot_err, e_oh);
    check({tag, ".seg"}, seg, 7'h7F);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, ".idx"}, idx, 0);
    check({tag, ".idx_valid"}, idx_valid, 0);
    check({tag, ".onehot_err"}, onehot_err, 0);
    check({tag, ".seq_err"}, seq_err, 0);
    check({tag, ".locked"}, locked, 0);
    check({tag, ".err_count"}, err_count, 0);
    check({tag, ".lap_count"}, lap_count, 0);
    check({tag, ".seg"}, seg, 7'h7F);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    pat_in    = 8'h00;
    pat_valid = 1'b0;
    #1;
    check_all_reset("rst_hold");
    #1 reset = 1'b1;
    #1;
    check_all_reset("rst_rel");

    // Three clean laps from phase 0; the first is only partly tracked.
    for (int lap = 0; lap < 3; lap++) begin
      for (int p = 0; p < 16; p++) begin
        step("clean", seq_tab[p], idx_tab[p], (lap > 0) || (p >= 13), 1'b0, 1'b0);
      end
      check("clean.lap_count", lap_count, lap);
      check("clean.err_count", err_count, 0);
    end

    // Multi-bit sample at phase 5.
    for (int p = 0; p < 16; p++) begin
      if (p == 5) begin
        step("mbit", 8'h18, 4, 1'b1, 1'b1, 1'b1);
        check("mbit.err_count", err_count, 1);
      end else begin
        step("mbit_lap", seq_tab[p], idx_tab[p], 1'b1, 1'b0, 1'b0);
      end
    end
    check("mbit.lap_count", lap_count, 3);

    // Three consecutive misses drop lock; next 80 relocks.
    step("loss_p0", 8'h01, 0, 1'b1, 1'b0, 1'b0);
    step("loss_p1", 8'h00, 0, 1'b1, 1'b1, 1'b0);
    step("loss_p2", 8'h00, 0, 1'b1, 1'b1, 1'b0);
    step("loss_p3", 8'h00, 0, 1'b0, 1'b1, 1'b0);
    check("loss.err_count", err_count, 4);
    step("sync_01", 8'h01, 0, 1'b0, 1'b0, 1'b0);
    step("relock", 8'h80, 7, 1'b1, 1'b0, 1'b0);
    step("relock_p14", 8'h00, 0, 1'b1, 1'b0, 1'b0);
    step("relock_p15", 8'h00, 0, 1'b1, 1'b0, 1'b0);
    check("relock.lap_count", lap_count, 3);
    check("relock.err_count", err_count, 4);

    // Stall mid-lap: nothing moves while pat_valid is low.
    for (int p = 0; p < 4; p++) begin
      step("stall_pre", seq_tab[p], idx_tab[p], 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      drive(8'hFF, 1'b0);
      check("stall.idx_valid", idx_valid, 0);
      check("stall.idx", idx, 2);
      check("stall.onehot_err", onehot_err, 0);
      check("stall.locked", locked, 1);
    end
    for (int p = 4; p < 16; p++) begin
      step("stall_post", seq_tab[p], idx_tab[p], 1'b1, 1'b0, 1'b0);
    end
    check("stall.err_count", err_count, 4);
    check("stall.lap_count", lap_count, 4);

    // 261 mismatches in groups of three (relock, then FF at phases 14, 15, 0).
    exp_err = 4;
    for (int g = 0; g < 87; g++) begin
      drive(8'h80, 1'b1);
      drive(8'hFF, 1'b1);
      drive(8'hFF, 1'b1);
      drive(8'hFF, 1'b1);
      exp_err = (exp_err + 3 > 255) ? 255 : exp_err + 3;
      check("sat.err_count", err_count, exp_err);
      check("sat.locked", locked, 0);
    end
    check("sat.final", err_count, 8'hFF);
    check("sat.lap_count", lap_count, 4);

    // Async reset in the middle of a tracked lap.
    step("pre_rst", 8'h80, 7, 1'b1, 1'b0, 1'b0);
    step("pre_rst", 8'h00, 0, 1'b1, 1'b0, 1'b0);
    step("pre_rst", 8'h00, 0, 1'b1, 1'b0, 1'b0);
    step("pre_rst", 8'h01, 0, 1'b1, 1'b0, 1'b0);
    step("pre_rst", 8'h02, 1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_all_reset("async_rst");
    #1 reset = 1'b1;
    step("post_rst_01", 8'h01, 0, 1'b0, 1'b0, 1'b0);
    step("post_rst_80", 8'h80, 7, 1'b1, 1'b0, 1'b0);
    check("post_rst.err_count", err_count, 0);
    check("post_rst.lap_count", lap_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
